// File: rtl/rf_write_arbiter.sv
// Two-port writeback arbiter for the register file's single edge-triggered write port.
// Default build: fixed priority (A over B) with a B starvation counter; define RF_WR_RR_EN for round-robin.
module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enabled,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accepting;
    logic              b_wins;
    logic              grant_a;
    logic              grant_b;
    logic              xfer;
    logic              xfer_nz;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    // Ready is held off while reset is asserted, even though the state already reads IDLE.
    assign accepting = ((state == IDLE) || (state == STROBE)) && !rst;

`ifdef RF_WR_RR_EN
    logic last_b;

    assign b_wins = b_valid && (!a_valid || !last_b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (xfer) begin
            last_b <= grant_b;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt;

    assign b_wins = b_valid && (!a_valid || (wait_cnt == LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (grant_b) begin
            wait_cnt <= 4'd0;
        end else if (accepting && b_valid && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end
`endif

    assign grant_b  = accepting && b_wins;
    assign grant_a  = accepting && a_valid && !b_wins;
    assign a_ready  = grant_a;
    assign b_ready  = grant_b;
    assign xfer     = grant_a || grant_b;
    assign sel_rd   = grant_b ? b_rd : a_rd;
    assign sel_data = grant_b ? b_data : a_data;
    assign xfer_nz  = xfer && (sel_rd != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = xfer_nz ? SETUP : IDLE;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = xfer_nz ? SETUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobe and busy come straight from flops so the register file sees a clean edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            rf_rd            <= '0;
            rf_write_data    <= '0;
            rf_write_enabled <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_nxt;
            rf_write_enabled <= (state_nxt == STROBE);
            busy             <= (state_nxt != IDLE);
            if (xfer_nz) begin
                rf_rd         <= sel_rd;
                rf_write_data <= sel_data;
            end
        end
    end

endmodule
